// File: rtl/tm_width_meter.sv
// Measures the high time of a Tm pulse in ce ticks, reporting it with an ok strobe and ovf/gl flags.
// Define TM_SYNC_EN to insert a two-flop synchronizer on Tm when it comes from an asynchronous source.
module tm_width_meter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         Tm,
  output logic [W-1:0] dat,
  output logic         ok,
  output logic         ovf,
  output logic         gl,
  output logic         busy
);

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  state_t         r_state, w_state_nxt;
  logic           r_tm_r, r_tm_p;
  logic           w_tm_in, w_rise, w_fall;
  logic [W-1:0]   r_cnt, w_cnt_nxt;
  logic           r_sat, w_sat_nxt;
  logic [W-1:0]   r_dat, w_dat_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic           r_gl, w_gl_nxt;
  logic           r_ok, w_ok_nxt;

`ifdef TM_SYNC_EN
  logic r_sync1, r_sync2;

  // Reset high so a marker already asserted at reset release is not mistaken for a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Tm;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tm_in = r_sync2;
`else
  assign w_tm_in = Tm;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tm_r <= 1'b1;
      r_tm_p <= 1'b1;
    end else begin
      r_tm_r <= w_tm_in;
      r_tm_p <= r_tm_r;
    end
  end

  assign w_rise = r_tm_r & ~r_tm_p;
  assign w_fall = ~r_tm_r & r_tm_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_dat   <= '0;
      r_ovf   <= 1'b0;
      r_gl    <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
      r_dat   <= w_dat_nxt;
      r_ovf   <= w_ovf_nxt;
      r_gl    <= w_gl_nxt;
      r_ok    <= w_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    w_dat_nxt   = r_dat;
    w_ovf_nxt   = r_ovf;
    w_gl_nxt    = r_gl;
    w_ok_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_MEAS;
          w_cnt_nxt   = {{(W-1){1'b0}}, ce};
          w_sat_nxt   = 1'b0;
        end
      end
      S_MEAS: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_dat_nxt   = r_cnt;
          w_ovf_nxt   = r_sat;
          w_gl_nxt    = (r_cnt == '0);
          w_ok_nxt    = 1'b1;
        end else if (r_tm_r && ce) begin
          // Counter sticks at full scale; sat remembers that ticks were lost.
          if (r_cnt == CNT_MAX) w_sat_nxt = 1'b1;
          else                  w_cnt_nxt = r_cnt + W'(1);
        end
      end
    endcase
  end

  assign dat  = r_dat;
  assign ok   = r_ok;
  assign ovf  = r_ovf;
  assign gl   = r_gl;
  assign busy = (r_state == S_MEAS);

endmodule
